// File: rtl/afe_ro_udma_drain.sv
// AFE readout -> uDMA RX sequencer with drain-before-shutdown and wake-up delay.
// Optional OFF-state sample flushing with a discard counter: AFE_RO_UDMA_DRAIN_FLUSH_EN.
module afe_ro_udma_drain #(
    parameter int DATA_WIDTH    = 32,
    parameter int DRAIN_TIMEOUT = 64,
    parameter int WAKE_CYCLES   = 4,
    parameter int CNT_WIDTH     = 16
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic                  cfg_udma_shtdwn_i,
    input  logic [DATA_WIDTH-1:0] afe_data_i,
    input  logic                  afe_valid_i,
    output logic                  afe_ready_o,
    output logic [DATA_WIDTH-1:0] udma_data_o,
    output logic                  udma_valid_o,
    input  logic                  udma_ready_i,
    output logic                  udma_shtdwn_o,
    output logic                  busy_o,
    output logic                  drop_o,
    output logic [CNT_WIDTH-1:0]  flush_cnt_o
);

    typedef enum logic [1:0] {RUN, DRAIN, OFF, WAKE} state_e;

    localparam logic [7:0] TIMEOUT_INIT = 8'(DRAIN_TIMEOUT);
    localparam logic [7:0] WAKE_INIT    = 8'(WAKE_CYCLES);

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  valid_q, valid_d;
    logic                  shtdwn_q, shtdwn_d;
    logic                  busy_q, busy_d;
    logic                  drop_q, drop_d;
    logic [7:0]            timer_q, timer_d;
    logic [7:0]            wake_q, wake_d;
    logic                  afe_ready;

`ifdef AFE_RO_UDMA_DRAIN_FLUSH_EN
    logic [CNT_WIDTH-1:0]  flush_cnt_q, flush_cnt_d;
`endif

    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        valid_d   = valid_q;
        drop_d    = drop_q;
        timer_d   = timer_q;
        wake_d    = wake_q;
        afe_ready = 1'b0;
`ifdef AFE_RO_UDMA_DRAIN_FLUSH_EN
        flush_cnt_d = flush_cnt_q;
`endif
        case (state_q)
            RUN: begin
                afe_ready = ~valid_q | udma_ready_i;
                if (afe_valid_i && afe_ready) begin
                    data_d  = afe_data_i;
                    valid_d = 1'b1;
                end else if (valid_q && udma_ready_i) begin
                    valid_d = 1'b0;
                end
                if (cfg_udma_shtdwn_i) begin
                    state_d = DRAIN;
                    timer_d = TIMEOUT_INIT;
                end
            end
            DRAIN: begin
                if (!valid_q || udma_ready_i) begin
                    valid_d = 1'b0;
                    state_d = OFF;
                end else if (timer_q == 8'd0) begin
                    // uDMA never took the word: give up on it and flag the loss.
                    valid_d = 1'b0;
                    drop_d  = 1'b1;
                    state_d = OFF;
                end else begin
                    timer_d = timer_q - 8'd1;
                end
            end
            OFF: begin
                valid_d = 1'b0;
`ifdef AFE_RO_UDMA_DRAIN_FLUSH_EN
                afe_ready = 1'b1;
                if (afe_valid_i && (flush_cnt_q != '1)) begin
                    flush_cnt_d = flush_cnt_q + 1'b1;
                end
`endif
                if (!cfg_udma_shtdwn_i) begin
                    state_d = WAKE;
                    wake_d  = WAKE_INIT;
                    drop_d  = 1'b0;
                end
            end
            WAKE: begin
                if (cfg_udma_shtdwn_i) begin
                    state_d = OFF;
                end else if (wake_q == 8'd1) begin
                    state_d = RUN;
`ifdef AFE_RO_UDMA_DRAIN_FLUSH_EN
                    flush_cnt_d = '0;
`endif
                end else begin
                    wake_d = wake_q - 8'd1;
                end
            end
            default: state_d = RUN;
        endcase
        // Status outputs are registered from the next state so they line up with it.
        shtdwn_d = (state_d == OFF);
        busy_d   = (state_d == DRAIN) || (state_d == WAKE);
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q  <= RUN;
            data_q   <= '0;
            valid_q  <= 1'b0;
            shtdwn_q <= 1'b0;
            busy_q   <= 1'b0;
            drop_q   <= 1'b0;
            timer_q  <= '0;
            wake_q   <= '0;
        end else begin
            state_q  <= state_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            shtdwn_q <= shtdwn_d;
            busy_q   <= busy_d;
            drop_q   <= drop_d;
            timer_q  <= timer_d;
            wake_q   <= wake_d;
        end
    end

`ifdef AFE_RO_UDMA_DRAIN_FLUSH_EN
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            flush_cnt_q <= '0;
        end else begin
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign flush_cnt_o = flush_cnt_q;
`else
    assign flush_cnt_o = '0;
`endif

    assign afe_ready_o   = afe_ready;
    assign udma_data_o   = data_q;
    assign udma_valid_o  = valid_q;
    assign udma_shtdwn_o = shtdwn_q;
    assign busy_o        = busy_q;
    assign drop_o        = drop_q;

endmodule

// File: tb/tb_afe_ro_udma_drain.sv
// Self-checking bench for afe_ro_udma_drain: scoreboard on the sample stream plus
// directed cycle-exact checks of the shutdown/drain/wake sequencing.
module tb_afe_ro_udma_drain;

    localparam int DW = 32;
    localparam int CW = 16;

`ifdef AFE_RO_UDMA_DRAIN_FLUSH_EN
    localparam bit FLUSH_ON = 1'b1;
`else
    localparam bit FLUSH_ON = 1'b0;
`endif

    logic          clk_i = 1'b0;
    logic          rstn_i;
    logic          cfg_udma_shtdwn_i;
    logic [DW-1:0] afe_data_i;
    logic          afe_valid_i;
    logic          afe_ready_o;
    logic [DW-1:0] udma_data_o;
    logic          udma_valid_o;
    logic          udma_ready_i;
    logic          udma_shtdwn_o;
    logic          busy_o;
    logic          drop_o;
    logic [CW-1:0] flush_cnt_o;

    int            total = 0;
    int            bad = 0;
    logic          sbEnable = 1'b0;
    logic [DW-1:0] sb[$];
    logic          prevStall = 1'b0;
    logic [DW-1:0] prevData = '0;

    afe_ro_udma_drain #(
        .DATA_WIDTH(DW), .DRAIN_TIMEOUT(64), .WAKE_CYCLES(4), .CNT_WIDTH(CW)
    ) dut (
        .clk_i(clk_i), .rstn_i(rstn_i), .cfg_udma_shtdwn_i(cfg_udma_shtdwn_i),
        .afe_data_i(afe_data_i), .afe_valid_i(afe_valid_i), .afe_ready_o(afe_ready_o),
        .udma_data_o(udma_data_o), .udma_valid_o(udma_valid_o), .udma_ready_i(udma_ready_i),
        .udma_shtdwn_o(udma_shtdwn_o), .busy_o(busy_o), .drop_o(drop_o),
        .flush_cnt_o(flush_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [DW-1:0] d,
                                 input logic r, input logic c);
        @(posedge clk_i);
        #1;
        afe_valid_i       = v;
        afe_data_i        = d;
        udma_ready_i      = r;
        cfg_udma_shtdwn_i = c;
    endtask

    task automatic sample();
        @(negedge clk_i);
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, "_valid"},  udma_valid_o,  0);
        checkOutput({tag, "_data"},   udma_data_o,   0);
        checkOutput({tag, "_shtdwn"}, udma_shtdwn_o, 0);
        checkOutput({tag, "_busy"},   busy_o,        0);
        checkOutput({tag, "_drop"},   drop_o,        0);
        checkOutput({tag, "_flush"},  flush_cnt_o,   0);
        checkOutput({tag, "_ready"},  afe_ready_o,   1);
    endtask

    // Release from OFF: one more OFF cycle, four WAKE cycles (with samples offered
    // that must not be taken), then RUN.
    task automatic wakeUp(input int flushInWake);
        sbEnable = 1'b0;
        applyStimulus(0, 0, 1, 0);
        sample();
        checkOutput("wake_off_shtdwn", udma_shtdwn_o, 1);
        for (int k = 1; k <= 4; k++) begin
            applyStimulus(1, 32'hDEAD_0000 + k, 1, 0);
            sample();
            checkOutput("wake_shtdwn", udma_shtdwn_o, 0);
            checkOutput("wake_busy", busy_o, 1);
            checkOutput("wake_ready", afe_ready_o, 0);
            checkOutput("wake_drop", drop_o, 0);
            checkOutput("wake_flush", flush_cnt_o, flushInWake);
        end
        applyStimulus(0, 0, 1, 0);
        sample();
        sbEnable = 1'b1;
        checkOutput("run_busy", busy_o, 0);
        checkOutput("run_ready", afe_ready_o, 1);
        checkOutput("run_flush", flush_cnt_o, 0);
        checkOutput("run_valid", udma_valid_o, 0);
    endtask

    // Stream scoreboard: every accepted sample must leave in order, exactly once,
    // and the output word must not change while stalled.
    always @(negedge clk_i) begin
        if (!rstn_i) begin
            sb.delete();
            prevStall = 1'b0;
        end else begin
            if (prevStall) checkOutput("hold_data", udma_data_o, prevData);
            if (udma_valid_o && udma_ready_i) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL out_unexpected: got 0x%0h, expected no word", udma_data_o);
                end else begin
                    checkOutput("out_order", udma_data_o, sb.pop_front());
                end
            end
            if (afe_valid_i && afe_ready_o && sbEnable) sb.push_back(afe_data_i);
            prevStall = udma_valid_o && !udma_ready_i;
            prevData  = udma_data_o;
        end
    end

    initial begin
        rstn_i = 1'b0;
        cfg_udma_shtdwn_i = 1'b0;
        afe_data_i = '0;
        afe_valid_i = 1'b0;
        udma_ready_i = 1'b0;
        applyStimulus(0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0);
        sample();
        checkReset("reset");
        applyStimulus(0, 0, 0, 0);
        rstn_i = 1'b1;
        sample();
        checkReset("post_reset");

        $display("[TB] stream 0x1..0x10");
        sbEnable = 1'b1;
        for (int i = 0; i <= 17; i++) begin
            applyStimulus(i < 16, i + 1, 1, 0);
            sample();
            if (i >= 1 && i <= 16) begin
                checkOutput("stream_valid", udma_valid_o, 1);
                checkOutput("stream_data", udma_data_o, i);
            end
            if (i == 17) checkOutput("stream_idle", udma_valid_o, 0);
            checkOutput("stream_shtdwn", udma_shtdwn_o, 0);
        end

        $display("[TB] drain with late ready");
        applyStimulus(1, 32'hA5A5_0001, 0, 0);
        sample();
        checkOutput("pend_accept", afe_ready_o, 1);
        applyStimulus(0, 0, 0, 1);
        sample();
        checkOutput("pend_valid", udma_valid_o, 1);
        checkOutput("pend_data", udma_data_o, 32'hA5A5_0001);
        checkOutput("pend_ready", afe_ready_o, 0);
        for (int k = 1; k <= 12; k++) begin
            applyStimulus(1, 32'hBAD0_0000 + k, k >= 11, 1);
            sample();
            if (k <= 11) begin
                checkOutput("drain_ready", afe_ready_o, 0);
                checkOutput("drain_busy", busy_o, 1);
                checkOutput("drain_shtdwn", udma_shtdwn_o, 0);
                checkOutput("drain_valid", udma_valid_o, 1);
            end else begin
                checkOutput("drain_off_shtdwn", udma_shtdwn_o, 1);
                checkOutput("drain_off_valid", udma_valid_o, 0);
                checkOutput("drain_off_drop", drop_o, 0);
                checkOutput("drain_off_busy", busy_o, 0);
                checkOutput("drain_delivered", sb.size(), 0);
            end
            if (k == 11) sbEnable = 1'b0;
        end
        applyStimulus(0, 0, 1, 1);
        wakeUp(0);

        $display("[TB] drain timeout");
        applyStimulus(1, 32'hA5A5_0002, 0, 0);
        sample();
        applyStimulus(0, 0, 0, 1);
        sample();
        checkOutput("to_valid", udma_valid_o, 1);
        for (int k = 1; k <= 67; k++) begin
            applyStimulus(0, 0, 0, 1);
            sample();
            if (k <= 65) begin
                checkOutput("to_wait_valid", udma_valid_o, 1);
                checkOutput("to_wait_drop", drop_o, 0);
                checkOutput("to_wait_shtdwn", udma_shtdwn_o, 0);
                checkOutput("to_wait_busy", busy_o, 1);
            end else begin
                checkOutput("to_valid_clr", udma_valid_o, 0);
                checkOutput("to_drop", drop_o, 1);
                checkOutput("to_shtdwn", udma_shtdwn_o, 1);
                checkOutput("to_data_kept", udma_data_o, 32'hA5A5_0002);
                if (k == 66 && sb.size() > 0) void'(sb.pop_front());
            end
        end

        $display("[TB] samples offered while off");
        sbEnable = 1'b0;
        for (int k = 0; k < 300; k++) begin
            applyStimulus(1, k, 0, 1);
            sample();
            checkOutput("off_ready", afe_ready_o, FLUSH_ON);
        end
        applyStimulus(0, 0, 0, 1);
        sample();
        checkOutput("off_flush", flush_cnt_o, FLUSH_ON ? 300 : 0);
        checkOutput("off_drop_sticky", drop_o, 1);
        wakeUp(FLUSH_ON ? 300 : 0);

        $display("[TB] re-shutdown during wake");
        applyStimulus(0, 0, 1, 1);
        sample();
        checkOutput("req_ready", afe_ready_o, 1);
        applyStimulus(0, 0, 1, 1);
        sample();
        checkOutput("empty_drain_busy", busy_o, 1);
        checkOutput("empty_drain_shtdwn", udma_shtdwn_o, 0);
        applyStimulus(0, 0, 1, 1);
        sample();
        checkOutput("empty_off_shtdwn", udma_shtdwn_o, 1);
        checkOutput("empty_off_busy", busy_o, 0);
        sbEnable = 1'b0;
        applyStimulus(0, 0, 1, 0);
        sample();
        checkOutput("rw_off_shtdwn", udma_shtdwn_o, 1);
        for (int k = 1; k <= 4; k++) begin
            applyStimulus(k <= 2, 32'hDEAD_1000 + k, 1, k >= 2);
            sample();
            checkOutput("rw_shtdwn", udma_shtdwn_o, k >= 3);
            checkOutput("rw_busy", busy_o, k <= 2);
            if (k <= 2) checkOutput("rw_ready", afe_ready_o, 0);
        end
        wakeUp(0);

        $display("[TB] reset during drain");
        applyStimulus(1, 32'hA5A5_0003, 0, 0);
        sample();
        applyStimulus(0, 0, 0, 1);
        sample();
        applyStimulus(0, 0, 0, 1);
        sample();
        checkOutput("rst_pre_busy", busy_o, 1);
        applyStimulus(0, 0, 0, 1);
        rstn_i = 1'b0;
        #1;
        checkReset("mid_reset");
        applyStimulus(0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0);
        rstn_i = 1'b1;
        sample();
        checkReset("after_reset");
        for (int i = 0; i <= 4; i++) begin
            applyStimulus(i < 4, 32'h100 + i, 1, 0);
            sample();
            if (i >= 1) begin
                checkOutput("resume_valid", udma_valid_o, 1);
                checkOutput("resume_data", udma_data_o, 32'h100 + i - 1);
            end
        end
        applyStimulus(0, 0, 1, 0);
        sample();
        checkOutput("resume_empty", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
